// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: parity modes, FSM encoding,
// and the occupancy-counter width helper.
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Occupancy needs one more code than the depth so full and empty differ.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with registered occupancy, full and empty flags.
module sync_fifo import uart_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  // Acceptance is judged on the pre-edge flags, so a push into a full FIFO
  // is refused even if a pop frees a slot on the same edge.
  assign push_ok = push && !full_q;
  assign pop_ok  = pop && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;
endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO feeding a start/data/parity/stop serializer
// with a sticky overflow flag. Every output is a flop.
module uart_tx_fifo import uart_pkg::*; #(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  localparam int CW = cnt_w(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_ovf,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              busy,
  output logic              tx_done,
  output logic              tx
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = 3;

  tx_state_e         state_q, state_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [IW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d, fifo_rdata;
  logic              par_q, par_d, tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic              ovf_q, ovf_d, pop, load, baud_last;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .areset(areset),
    .push  (wr_en),
    .pop   (pop),
    .wdata (wr_data),
    .rdata (fifo_rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));
  // A dropped write outranks a clear on the same edge.
  assign ovf_d = (wr_en && full) ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        load = !empty;
      end
      ST_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end else baud_d = baud_q + 1'b1;
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == IW'(DATA_W - 1)) begin
            bit_d = '0;
            if (PARITY != PAR_NONE) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else baud_d = baud_q + 1'b1;
      end
      ST_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end else baud_d = baud_q + 1'b1;
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == IW'(STOP_BITS - 1)) begin
            if (!empty) load = 1'b1;
            else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end
          end else bit_d = bit_q + 1'b1;
        end else baud_d = baud_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Frame data and its parity are captured at pop time only.
    if (load) begin
      pop     = 1'b1;
      shift_d = fifo_rdata;
      par_d   = (^fifo_rdata) ^ (PARITY == PAR_ODD);
      baud_d  = '0;
      state_d = ST_START;
      tx_d    = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
    // Registered pulse must already be high during the last stop cycle.
    done_d = (state_d == ST_STOP) && (baud_d == BW'(CLKS_PER_BIT - 1)) &&
             (bit_d == IW'(STOP_BITS - 1));
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: four UART configurations sharing one clock and reset.
module tb_uart_tx_fifo;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic areset;
  logic [3:0]      wr_en, clr_ovf, full, empty, overflow, busy, tx_done, tx;
  logic [3:0][7:0] wr_data;
  logic [3:0][2:0] count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .areset(areset), .wr_en(wr_en[0]), .wr_data(wr_data[0]), .clr_ovf(clr_ovf[0]),
    .full(full[0]), .empty(empty[0]), .count(count[0]), .overflow(overflow[0]),
    .busy(busy[0]), .tx_done(tx_done[0]), .tx(tx[0]));
  uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .areset(areset), .wr_en(wr_en[1]), .wr_data(wr_data[1]), .clr_ovf(clr_ovf[1]),
    .full(full[1]), .empty(empty[1]), .count(count[1]), .overflow(overflow[1]),
    .busy(busy[1]), .tx_done(tx_done[1]), .tx(tx[1]));
  uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .areset(areset), .wr_en(wr_en[2]), .wr_data(wr_data[2]), .clr_ovf(clr_ovf[2]),
    .full(full[2]), .empty(empty[2]), .count(count[2]), .overflow(overflow[2]),
    .busy(busy[2]), .tx_done(tx_done[2]), .tx(tx[2]));
  uart_tx_fifo #(.DATA_W(7), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .areset(areset), .wr_en(wr_en[3]), .wr_data(wr_data[3][6:0]), .clr_ovf(clr_ovf[3]),
    .full(full[3]), .empty(empty[3]), .count(count[3]), .overflow(overflow[3]),
    .busy(busy[3]), .tx_done(tx_done[3]), .tx(tx[3]));

  typedef struct {
    int         dut;
    logic [7:0] data;
    string      bits;  // expected line level per bit slot, first-sent first
    string      name;
  } frame_vec_t;

  frame_vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Current sample is cycle 1 of the frame; returns at the sample of its last cycle.
  task automatic check_frame(input int d, input string bits, input string nm);
    int   len;
    logic exp;
    len = bits.len() * CPB;
    for (int n = 1; n <= len; n++) begin
      if (n > 1) tick();
      exp = (bits[(n-1)/CPB] == 8'h31);
      chk($sformatf("%s_tx_c%0d", nm, n), 32'(tx[d]), 32'(exp));
      chk($sformatf("%s_done_c%0d", nm, n), 32'(tx_done[d]), 32'(n == len));
      chk($sformatf("%s_busy_c%0d", nm, n), 32'(busy[d]), 32'd1);
    end
  endtask

  task automatic run_frame(input int d, input logic [7:0] data, input string bits, input string nm);
    wr_data[d] = data;
    wr_en[d]   = 1'b1;
    tick();
    wr_en[d] = 1'b0;
    chk({nm, "_queued_cnt"}, 32'(count[d]), 32'd1);
    chk({nm, "_queued_tx"}, 32'(tx[d]), 32'd1);
    tick();
    check_frame(d, bits, nm);
    tick();
    chk({nm, "_after_busy"}, 32'(busy[d]), 32'd0);
    chk({nm, "_after_tx"}, 32'(tx[d]), 32'd1);
    chk({nm, "_after_empty"}, 32'(empty[d]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int         exp_cnt [6];
    logic       bad;
    vecs[0] = '{0, 8'h55, "0101010101",  "n1_55"};
    vecs[1] = '{0, 8'hA3, "0110001011",  "n1_A3"};
    vecs[2] = '{1, 8'h07, "01110000011", "e1_07"};
    vecs[3] = '{1, 8'h00, "00000000001", "e1_00"};
    vecs[4] = '{2, 8'h07, "01110000001", "o1_07"};
    vecs[5] = '{2, 8'h00, "00000000011", "o1_00"};
    vecs[6] = '{3, 8'h7F, "0111111111",  "n2_7F"};
    vecs[7] = '{3, 8'h2A, "0010101011",  "n2_2A"};
    exp_cnt = '{1, 1, 2, 3, 4, 4};

    areset = 1'b0; wr_en = '0; clr_ovf = '0; wr_data = '0;
    tick(); tick();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst%0d_tx", d), 32'(tx[d]), 32'd1);
      chk($sformatf("rst%0d_busy", d), 32'(busy[d]), 32'd0);
      chk($sformatf("rst%0d_cnt", d), 32'(count[d]), 32'd0);
      chk($sformatf("rst%0d_empty", d), 32'(empty[d]), 32'd1);
      chk($sformatf("rst%0d_full", d), 32'(full[d]), 32'd0);
      chk($sformatf("rst%0d_ovf", d), 32'(overflow[d]), 32'd0);
      chk($sformatf("rst%0d_done", d), 32'(tx_done[d]), 32'd0);
    end
    areset = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_frame(vecs[i].dut, vecs[i].data, vecs[i].bits, vecs[i].name);

    // Overflow: six writes into a depth-4 FIFO, one pop on the second edge.
    for (int i = 0; i < 6; i++) begin
      wr_data[0] = 8'hA0 + 8'(i);
      wr_en[0]   = 1'b1;
      tick();
      chk($sformatf("ovf_cnt_w%0d", i), 32'(count[0]), 32'(exp_cnt[i]));
    end
    wr_en[0] = 1'b0;
    chk("ovf_set", 32'(overflow[0]), 32'd1);
    chk("ovf_full", 32'(full[0]), 32'd1);
    clr_ovf[0] = 1'b1;
    tick();
    clr_ovf[0] = 1'b0;
    chk("ovf_clr", 32'(overflow[0]), 32'd0);
    repeat (34) tick();
    chk("a0_last_done", 32'(tx_done[0]), 32'd1);
    chk("a0_last_cnt", 32'(count[0]), 32'd4);
    // Write and clear on the pop edge while full: write dropped, set beats clear.
    wr_data[0] = 8'hEE; wr_en[0] = 1'b1; clr_ovf[0] = 1'b1;
    tick();
    wr_en[0] = 1'b0; clr_ovf[0] = 1'b0;
    chk("popfull_ovf", 32'(overflow[0]), 32'd1);
    chk("popfull_cnt", 32'(count[0]), 32'd3);
    chk("popfull_full", 32'(full[0]), 32'd0);
    check_frame(0, "0100001011", "b2b_A1"); tick();
    check_frame(0, "0010001011", "b2b_A2"); tick();
    check_frame(0, "0110001011", "b2b_A3"); tick();
    check_frame(0, "0001001011", "b2b_A4"); tick();
    chk("b2b_end_busy", 32'(busy[0]), 32'd0);
    chk("b2b_end_empty", 32'(empty[0]), 32'd1);
    clr_ovf[0] = 1'b1;
    tick();
    clr_ovf[0] = 1'b0;
    chk("ovf_clr2", 32'(overflow[0]), 32'd0);

    // Mid-frame asynchronous reset with two bytes still queued.
    wr_en[0] = 1'b1;
    wr_data[0] = 8'h3C; tick();
    wr_data[0] = 8'hC3; tick();
    wr_data[0] = 8'h5A; tick();
    wr_en[0] = 1'b0;
    chk("mrst_pre_cnt", 32'(count[0]), 32'd2);
    repeat (16) tick();
    chk("mrst_pre_bit3", 32'(tx[0]), 32'd1);
    chk("mrst_pre_busy", 32'(busy[0]), 32'd1);
    #1 areset = 1'b0;
    #1;
    chk("mrst_tx", 32'(tx[0]), 32'd1);
    chk("mrst_busy", 32'(busy[0]), 32'd0);
    chk("mrst_cnt", 32'(count[0]), 32'd0);
    chk("mrst_empty", 32'(empty[0]), 32'd1);
    chk("mrst_full", 32'(full[0]), 32'd0);
    tick(); tick();
    areset = 1'b1;
    bad = 1'b0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad = 1'b1;
    end
    chk("mrst_no_frame", 32'(bad), 32'd0);
    chk("mrst_post_cnt", 32'(count[0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
